// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_ctrl_pkg : shared types and widths for fifo_array_ctrl.    |
// | Revision: 1.0                                                   |
// +------------------------------------------------------------------+
package fifo_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_LOADED = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // Widths for the default bank (9 FIFOs of 256 words).
   localparam int ARRAY_SIZE_DEF = 9;
   localparam int LOG_DEPTH_DEF  = 8;
   localparam int ROW_W = $clog2(ARRAY_SIZE_DEF);
   localparam int LEN_W = LOG_DEPTH_DEF + 1;
   localparam int T_W   = LEN_W + ROW_W;

endpackage
`default_nettype wire

// File: rtl/fifo_array_ctrl_skew_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | skew_scheduler : per-lane read schedule for the drain phase.     |
// | FIFO_ARRAY_CTRL_SKEW_EN selects diagonal skew, else lockstep.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module skew_scheduler
   import fifo_ctrl_pkg::*;
#(
   parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
   parameter int LEN_W_P    = LEN_W,
   parameter int T_W_P      = T_W
) (
   input  logic [T_W_P-1:0]      t_i,
   input  logic [LEN_W_P-1:0]    len_i,
   output logic [ARRAY_SIZE-1:0] sched_o,
   output logic                  last_o
);

   localparam int EW = T_W_P + 1;

   logic [EW-1:0] t_ext;
   logic [EW-1:0] len_ext;

   assign t_ext   = EW'(t_i);
   assign len_ext = EW'(len_i);

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
`ifdef FIFO_ARRAY_CTRL_SKEW_EN
      assign sched_o[i] = (t_ext >= EW'(i)) && (t_ext < (EW'(i) + len_ext));
`else
      assign sched_o[i] = (t_ext < len_ext);
`endif
   end

`ifdef FIFO_ARRAY_CTRL_SKEW_EN
   assign last_o = (t_ext == (len_ext + EW'(ARRAY_SIZE - 2)));
`else
   assign last_o = (t_ext == (len_ext - EW'(1)));
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_array_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_array_ctrl : fill/drain sequencer for the fifo_array bank.  |
// | Optional macro FIFO_ARRAY_CTRL_SKEW_EN enables diagonal skew.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fifo_array_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 256,
   parameter int LOG_DEPTH  = 8,
   parameter int ARRAY_SIZE = 9
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [LOG_DEPTH:0]    cfg_len,
   input  logic                  load_start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  start,
   input  logic [ARRAY_SIZE-1:0] fifo_full,
   input  logic [ARRAY_SIZE-1:0] fifo_empty,
   output logic [ARRAY_SIZE-1:0] w_en,
   output logic [ARRAY_SIZE-1:0] r_en,
   output logic                  fifo_clr,
   output logic [ARRAY_SIZE-1:0] out_valid,
   output logic                  loaded,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int ROW_BITS = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam int LEN_BITS = LOG_DEPTH + 1;
   localparam int T_BITS   = LEN_BITS + ROW_BITS;

   state_t                state_q, state_d;
   logic [ROW_BITS-1:0]   row_q, row_d;
   logic [LEN_BITS-1:0]   col_q, col_d;
   logic [LEN_BITS-1:0]   len_q, len_d;
   logic [T_BITS-1:0]     t_q, t_d;
   logic                  err_q, err_d;
   logic [ARRAY_SIZE-1:0] out_valid_q;

   logic [ARRAY_SIZE-1:0] sched;
   logic                  sched_last;
   logic                  hs;

   skew_scheduler #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .LEN_W_P    (LEN_BITS),
      .T_W_P      (T_BITS)
   ) u_sched (
      .t_i     (t_q),
      .len_i   (len_q),
      .sched_o (sched),
      .last_o  (sched_last)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         len_q       <= '0;
         t_q         <= '0;
         err_q       <= 1'b0;
         out_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         len_q       <= len_d;
         t_q         <= t_d;
         err_q       <= err_d;
         out_valid_q <= r_en;
      end
   end

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      len_d    = len_q;
      t_d      = t_q;
      err_d    = err_q;
      in_ready = 1'b0;
      w_en     = '0;
      r_en     = '0;
      fifo_clr = clear;
      loaded   = 1'b0;
      done     = 1'b0;
      hs       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (load_start && (cfg_len != '0) && (cfg_len <= LEN_BITS'(FIFO_DEPTH))) begin
               len_d    = cfg_len;
               row_d    = '0;
               col_d    = '0;
               fifo_clr = 1'b1;
               state_d  = S_FILL;
            end
         end
         S_FILL: begin
            // Enables are gated by clear so an abort takes effect in the same cycle.
            in_ready    = !fifo_full[row_q] && !clear;
            hs          = in_valid && in_ready;
            w_en[row_q] = hs;
            if (hs) begin
               if (col_q == (len_q - LEN_BITS'(1))) begin
                  col_d = '0;
                  if (row_q == ROW_BITS'(ARRAY_SIZE - 1)) begin
                     state_d = S_LOADED;
                  end else begin
                     row_d = row_q + ROW_BITS'(1);
                  end
               end else begin
                  col_d = col_q + LEN_BITS'(1);
               end
            end
         end
         S_LOADED: begin
            loaded = 1'b1;
            if (start) begin
               t_d     = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // An empty lane skips its read; the schedule keeps running regardless.
            if (!clear) begin
               r_en = sched & ~fifo_empty;
            end
            if ((sched & fifo_empty) != '0) begin
               err_d = 1'b1;
            end
            if (sched_last) begin
               state_d = S_DONE;
            end else begin
               t_d = t_q + T_BITS'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign out_valid = out_valid_q;
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_array_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_array_ctrl : directed bench for fifo_array_ctrl (4x8).   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fifo_array_ctrl;

   logic       clk = 1'b0;
   logic       clear;
   logic [3:0] cfg_len;
   logic       load_start;
   logic       in_valid;
   logic       in_ready;
   logic       start;
   logic [3:0] fifo_full;
   logic [3:0] fifo_empty;
   logic [3:0] w_en;
   logic [3:0] r_en;
   logic       fifo_clr;
   logic [3:0] out_valid;
   logic       loaded;
   logic       busy;
   logic       done;
   logic       err;

   int n_vec = 0;
   int n_err = 0;
   int n_exp;
   logic [3:0] exp_tab [0:7];

   always #5 clk = ~clk;

   fifo_array_ctrl #(
      .FIFO_DEPTH (8),
      .LOG_DEPTH  (3),
      .ARRAY_SIZE (4)
   ) dut (
      .clk        (clk),
      .clear      (clear),
      .cfg_len    (cfg_len),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .start      (start),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .w_en       (w_en),
      .r_en       (r_en),
      .fifo_clr   (fifo_clr),
      .out_valid  (out_valid),
      .loaded     (loaded),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fill(input int len, input int bp_k);
      int k;
      int bp_cnt;
      k      = 0;
      bp_cnt = 0;
      cfg_len    = 4'(len);
      load_start = 1'b1;
      #1;
      chk("fill_clr_pulse", fifo_clr, 1);
      tick();
      load_start = 1'b0;
      in_valid   = 1'b1;
      while (k < 4 * len) begin
         if (k == bp_k && bp_cnt < 2) begin
            fifo_full[k / len] = 1'b1;
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_w_en", w_en, 0);
            tick();
            bp_cnt++;
            fifo_full = '0;
         end else begin
            #1;
            chk("fill_in_ready", in_ready, 1);
            chk("fill_w_en", w_en, 16'(4'b0001 << (k / len)));
            chk("fill_busy", busy, 1);
            tick();
            k++;
         end
      end
      in_valid = 1'b0;
      #1;
      chk("loaded", loaded, 1);
      chk("loaded_w_en", w_en, 0);
      chk("loaded_in_ready", in_ready, 0);
   endtask

   task automatic do_drain(input logic [3:0] mask);
      logic [3:0] prev;
      prev       = '0;
      fifo_empty = mask;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < n_exp; c++) begin
         #1;
         chk("drain_r_en", r_en, 16'(exp_tab[c] & ~mask));
         chk("drain_out_valid", out_valid, 16'(prev));
         chk("drain_done", done, 0);
         prev = exp_tab[c] & ~mask;
         tick();
      end
      #1;
      chk("done_pulse", done, 1);
      chk("done_r_en", r_en, 0);
      chk("done_out_valid", out_valid, 16'(prev));
      tick();
      #1;
      chk("done_once", done, 0);
      chk("idle_busy", busy, 0);
      fifo_empty = '0;
   endtask

   initial begin
      clear      = 1'b1;
      cfg_len    = '0;
      load_start = 1'b0;
      in_valid   = 1'b0;
      start      = 1'b0;
      fifo_full  = '0;
      fifo_empty = '0;
      tick();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_w_en", w_en, 0);
      chk("rst_r_en", r_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_fifo_clr", fifo_clr, 1);
      clear = 1'b0;
      #1;
      chk("fifo_clr_low", fifo_clr, 0);

      // Out-of-range lengths and a stray start leave the block idle.
      cfg_len    = 4'd0;
      load_start = 1'b1;
      #1;
      chk("len0_clr", fifo_clr, 0);
      tick();
      #1;
      chk("len0_busy", busy, 0);
      cfg_len = 4'd9;
      #1;
      chk("len9_clr", fifo_clr, 0);
      tick();
      #1;
      chk("len9_busy", busy, 0);
      load_start = 1'b0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      #1;
      chk("idle_start_busy", busy, 0);

`ifdef FIFO_ARRAY_CTRL_SKEW_EN
      exp_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
      n_exp   = 6;
`else
      exp_tab = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      n_exp   = 3;
`endif
      // Fill with backpressure on FIFO 1 at its second word, then a clean drain.
      do_fill(3, 4);
      do_drain(4'b0000);
      chk("clean_err", err, 0);

      // Underflow on lane 2.
      do_fill(3, -1);
      do_drain(4'b0100);
      chk("underflow_err", err, 1);

      // Abort mid-drain at t=2.
      do_fill(3, -1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #1;
      chk("t2_r_en", r_en, 16'(exp_tab[2]));
      clear = 1'b1;
      #1;
      chk("clr_r_en_now", r_en, 0);
      chk("clr_fifo_clr", fifo_clr, 1);
      tick();
      clear = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_err", err, 0);
      chk("abort_r_en", r_en, 0);
      chk("abort_out_valid", out_valid, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      chk("abort_start_busy", busy, 0);
      chk("abort_start_r_en", r_en, 0);

`ifdef FIFO_ARRAY_CTRL_SKEW_EN
      exp_tab = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
      n_exp   = 5;
`else
      exp_tab = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      n_exp   = 2;
`endif
      do_fill(2, -1);
      do_drain(4'b0000);
      chk("len2_err", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
